sprite_draw_sequencer: RTL
==========================

Name: sprite_draw_sequencer

Overview:
Executes the CHIP-8/SCHIP DXYN draw instruction on behalf of the CPU core. It fetches sprite bytes from main RAM at I, issues one row at a time to video_controller over its draw_sprite/busy/colision handshake, and accumulates collision into a single VF result. It sits between the CPU execute stage (upstream) and video_controller (downstream).

Parameters:
ADDR_W, 12, main RAM address width (4 KB space)

Ports:
clk_100mhz  in  1  system clock
rst  in  1  reset
start  in  1  one-cycle pulse: begin DXYN; sampled only in IDLE
extended_video_mode  in  1  HIGH = 128x64 SCHIP mode, LOW = 64x32
x_coord  in  8  VX value, sampled on start
y_coord  in  8  VY value, sampled on start
n_rows  in  4  N nibble, sampled on start
index_reg  in  ADDR_W  I register, sampled on start
mem_addr  out  ADDR_W  RAM read address
mem_rd_en  out  1  RAM read strobe
mem_rd_data  in  8  RAM data, valid exactly 1 cycle after mem_rd_en
vc_sprite  out  16  row bits to video_controller, MSB = leftmost pixel
vc_draw_row  out  6  target row
vc_draw_col  out  7  target column
vc_draw_sprite  out  1  one-cycle draw request
vc_busy  in  1  video_controller busy
vc_colision  in  1  video_controller collision for last row
busy  out  1  HIGH whenever state != IDLE
done  out  1  one-cycle pulse when instruction completes
collision_flag  out  1  VF result; valid from done until next start

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk_100mhz. All outputs 0, state IDLE, internal registers 0. Reset mid-operation aborts immediately. No partial-row write is issued after release.
- Geometry on start:
  - wide = extended_video_mode && n_rows==0 (16x16, 2 bytes/row).
  - rows = 16 if n_rows==0, else n_rows. Lo-res N=0 draws 8x16, 1 byte/row.
- Column and row wrap:
  - col = x mod 64 (lo-res) or x mod 128 (hi-res). Horizontal wrap is done by video_controller rotation.
  - row_k = (y + k) mod 32 (lo-res) or mod 64 (hi-res), i.e. per-row vertical wrap.
- Sprite packing: narrow rows put the byte in vc_sprite[15:8] with [7:0]=0. Wide rows put byte0 in [15:8] and byte1 in [7:0].
- Address: ptr starts at index_reg and increments once per byte fetched, wrapping modulo 2^ADDR_W.
- States:
  - IDLE: on start, latch inputs, clear collision accumulator, go to WAIT_VC.
  - WAIT_VC: stay while vc_busy (e.g. a clear is in progress). Otherwise go to RD_HI.
  - RD_HI: mem_rd_en=1, mem_addr=ptr, ptr++. Go to RD_LO if wide, else CAP.
  - RD_LO: capture hi byte, mem_rd_en=1, mem_addr=ptr, ptr++. Go to CAP.
  - CAP: capture last byte into vc_sprite. Drive vc_draw_row/vc_draw_col. Go to ISSUE.
  - ISSUE: vc_draw_sprite=1 for exactly this cycle. Go to ACK.
  - ACK: wait one cycle for vc_busy to rise (controller asserts busy 1 cycle after sampling). Go to WAIT_DONE.
  - WAIT_DONE: stay while vc_busy. When low, acc |= vc_colision and k++. If k==rows, go to FIN, else RD_HI.
  - FIN: collision_flag <= acc, done=1. Go to IDLE.
- vc_sprite, vc_draw_row and vc_draw_col hold stable from CAP until the next CAP.
- start while busy is ignored. start in the same cycle as vc_busy=1 is accepted, and the FSM waits in WAIT_VC.
- vc_draw_sprite is never asserted while vc_busy=1.
- Latency, lo-res N=1 with vc idle and 4-cycle controller op: done follows start by 1+1+1+1+1+(4+1)+1 cycles. The bench checks the ordering, not an exact count, beyond ISSUE→ACK=1.

Decomposition:
- Shared package: state encoding; LORES_COLS=64, LORES_ROWS=32, HIRES_COLS=128, HIRES_ROWS=64; BIG_SPRITE_ROWS=16.
- One natural sub-module, sprite_geom_calc: combinational wide/rows/col/row_k computation. The rest stays in one FSM file.

Test Plan:
- Lo-res, x=10, y=5, N=3, I=0x300, RAM=F0,90,F0 → three requests with vc_sprite=F000/9000/F000, rows 5,6,7, col 10; ptr ends 0x303; collision_flag=0.
- Lo-res, y=30, N=4 → rows 30,31,0,1 (vertical wrap); x=70 → vc_draw_col=6.
- Hi-res, N=0, I=0xFFE → 16 requests, 2 bytes each, addresses FFE,FFF,000,...; first vc_sprite={RAM[FFE],RAM[FFF]}.
- Controller model returns vc_colision=1 on row 2 only of N=5 → collision_flag=1 at done; a subsequent draw with no hits → 0.
- start while model vc_busy=1 for 20 cycles → no mem_rd_en and no vc_draw_sprite until vc_busy falls; second start during busy ignored.
- rst pulsed during WAIT_DONE → all outputs 0 immediately, no further vc_draw_sprite; a fresh start then completes normally.

Source files
------------

// File: rtl/sprite_draw_sequencer_pkg.sv
// Shared definitions for the DXYN sprite draw sequencer: display geometry
// and the sequencer state encoding.
package sprite_draw_sequencer_pkg;

  // Display sizes for the two video modes (all powers of two, so wrapping
  // is a plain truncation of the coordinate bits).
  localparam int LORES_COLS      = 64;
  localparam int LORES_ROWS      = 32;
  localparam int HIRES_COLS      = 128;
  localparam int HIRES_ROWS      = 64;

  // Row count used when the N nibble is zero.
  localparam int BIG_SPRITE_ROWS = 16;

  localparam int LORES_COL_W = $clog2(LORES_COLS);
  localparam int LORES_ROW_W = $clog2(LORES_ROWS);
  localparam int HIRES_COL_W = $clog2(HIRES_COLS);
  localparam int HIRES_ROW_W = $clog2(HIRES_ROWS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_VC,
    S_RD_HI,
    S_RD_LO,
    S_CAP,
    S_ISSUE,
    S_ACK,
    S_WAIT_DONE,
    S_FIN
  } state_t;

endpackage

// File: rtl/sprite_draw_sequencer_geom.sv
// Combinational sprite geometry: sprite width/height from the N nibble and
// video mode, the wrapped start column and the wrapped target row for row k.
module sprite_geom_calc
  import sprite_draw_sequencer_pkg::*;
(
  input  logic       hires,
  input  logic [7:0] x_coord,
  input  logic [7:0] y_coord,
  input  logic [3:0] n_rows,
  input  logic [4:0] row_idx,
  output logic       wide,
  output logic [4:0] rows,
  output logic [6:0] col,
  output logic [5:0] row
);

  logic [7:0] row_sum;

  // Derive size and wrapped coordinates for the current row.
  always_comb begin
    // NOTE: every output gets a value on every path through this block,
    // otherwise synthesis infers a latch to hold the unassigned value.
    wide    = hires && (n_rows == 4'd0);
    rows    = (n_rows == 4'd0) ? 5'(BIG_SPRITE_ROWS) : {1'b0, n_rows};
    row_sum = y_coord + {3'b000, row_idx};
    if (hires) begin
      col = x_coord[HIRES_COL_W-1:0];
      row = row_sum[HIRES_ROW_W-1:0];
    end else begin
      col = {1'b0, x_coord[LORES_COL_W-1:0]};
      row = {1'b0, row_sum[LORES_ROW_W-1:0]};
    end
  end

endmodule

// File: rtl/sprite_draw_sequencer.sv
// DXYN draw sequencer: fetches sprite bytes from RAM starting at I, hands
// them to the video controller one row at a time and ORs the per-row
// collision results into a single VF value.
module sprite_draw_sequencer
  import sprite_draw_sequencer_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic              start,
  input  logic              extended_video_mode,
  input  logic [7:0]        x_coord,
  input  logic [7:0]        y_coord,
  input  logic [3:0]        n_rows,
  input  logic [ADDR_W-1:0] index_reg,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rd_data,
  output logic [15:0]       vc_sprite,
  output logic [5:0]        vc_draw_row,
  output logic [6:0]        vc_draw_col,
  output logic              vc_draw_sprite,
  input  logic              vc_busy,
  input  logic              vc_colision,
  output logic              busy,
  output logic              done,
  output logic              collision_flag
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state;
  logic              hires_q;
  logic [7:0]        x_q;
  logic [7:0]        y_q;
  logic [3:0]        n_q;
  logic [ADDR_W-1:0] ptr;
  logic [4:0]        row_k;
  logic              acc;
  logic [7:0]        hi_byte;

  logic              wide;
  logic [4:0]        rows;
  logic [6:0]        col;
  logic [5:0]        row;
  logic              acc_next;

  sprite_geom_calc u_geom (
    .hires   (hires_q),
    .x_coord (x_q),
    .y_coord (y_q),
    .n_rows  (n_q),
    .row_idx (row_k),
    .wide    (wide),
    .rows    (rows),
    .col     (col),
    .row     (row)
  );

  assign acc_next = acc | vc_colision;

  // Sequencer FSM; every output is a register updated on the transition
  // into the state that owns it.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      hires_q        <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      n_q            <= '0;
      ptr            <= '0;
      row_k          <= '0;
      acc            <= 1'b0;
      hi_byte        <= '0;
      mem_addr       <= '0;
      mem_rd_en      <= 1'b0;
      vc_sprite      <= '0;
      vc_draw_row    <= '0;
      vc_draw_col    <= '0;
      vc_draw_sprite <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      collision_flag <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees
      // the pre-edge values of the others regardless of statement order.
      mem_rd_en      <= 1'b0;
      vc_draw_sprite <= 1'b0;
      done           <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            hires_q <= extended_video_mode;
            x_q     <= x_coord;
            y_q     <= y_coord;
            n_q     <= n_rows;
            ptr     <= index_reg;
            row_k   <= '0;
            acc     <= 1'b0;
            busy    <= 1'b1;
            state   <= S_WAIT_VC;
          end
        end

        // Hold off while the controller is busy (e.g. a screen clear).
        S_WAIT_VC: begin
          if (!vc_busy) begin
            mem_rd_en <= 1'b1;
            mem_addr  <= ptr;
            ptr       <= ptr + ADDR_ONE;
            state     <= S_RD_HI;
          end
        end

        // Wide rows need a second byte; narrow rows go straight to capture.
        S_RD_HI: begin
          if (wide) begin
            mem_rd_en <= 1'b1;
            mem_addr  <= ptr;
            ptr       <= ptr + ADDR_ONE;
            state     <= S_RD_LO;
          end else begin
            state <= S_CAP;
          end
        end

        S_RD_LO: begin
          hi_byte <= mem_rd_data;
          state   <= S_CAP;
        end

        // Present the row and raise the draw request together.
        S_CAP: begin
          vc_sprite      <= wide ? {hi_byte, mem_rd_data} : {mem_rd_data, 8'h00};
          vc_draw_row    <= row;
          vc_draw_col    <= col;
          vc_draw_sprite <= 1'b1;
          state          <= S_ISSUE;
        end

        S_ISSUE: state <= S_ACK;

        // The controller raises busy one cycle after it samples the request.
        S_ACK: state <= S_WAIT_DONE;

        S_WAIT_DONE: begin
          if (!vc_busy) begin
            acc   <= acc_next;
            row_k <= row_k + 5'd1;
            if (row_k + 5'd1 == rows) begin
              collision_flag <= acc_next;
              done           <= 1'b1;
              state          <= S_FIN;
            end else begin
              mem_rd_en <= 1'b1;
              mem_addr  <= ptr;
              ptr       <= ptr + ADDR_ONE;
              state     <= S_RD_HI;
            end
          end
        end

        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
